// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per frame (start, data, optional parity, stop).
// Bit timing is driven by an external s_tick enable; each bit lasts OVERSAMPLE ticks.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 tx_done_flag,
    output logic                 tx
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] S_LAST    = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     s_cnt;
    logic [CNT_W-1:0]     s_cnt_n;
    logic [BIT_W-1:0]     b_cnt;
    logic [BIT_W-1:0]     b_cnt_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 par_bit;
    logic                 par_n;
    logic                 done_n;
    logic                 tx_n;
    logic                 bit_end;
    logic                 line_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            s_cnt        <= '0;
            b_cnt        <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            tx           <= 1'b1;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            tx_done_flag <= 1'b0;
        end else begin
            state        <= state_n;
            s_cnt        <= s_cnt_n;
            b_cnt        <= b_cnt_n;
            shreg        <= shreg_n;
            par_bit      <= par_n;
            tx           <= tx_n;
            tx_ready     <= (state_n == ST_IDLE);
            busy         <= (state_n != ST_IDLE);
            tx_done_flag <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        b_cnt_n = b_cnt;
        shreg_n = shreg;
        par_n   = par_bit;
        done_n  = 1'b0;
        bit_end = s_tick && (s_cnt == S_LAST);

        // Ticks advance the bit timer in every active state; a bit end below overrides it.
        if (s_tick && (state != ST_IDLE)) begin
            s_cnt_n = s_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_n = d_in;
                    par_n   = (PARITY == 1) ? ~^d_in : ^d_in;
                    s_cnt_n = '0;
                    b_cnt_n = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    if (MSB_FIRST != 0) begin
                        shreg_n = {shreg[DATA_BITS-2:0], 1'b0};
                    end else begin
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    end
                    if (b_cnt == DATA_LAST) begin
                        b_cnt_n = '0;
                        state_n = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    s_cnt_n = '0;
                    if (b_cnt == STOP_LAST) begin
                        b_cnt_n = '0;
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        b_cnt_n = b_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                s_cnt_n = '0;
                b_cnt_n = '0;
            end
        endcase

        // The line is registered from the next-state view so it tracks state without a lag.
        line_bit = (MSB_FIRST != 0) ? shreg_n[DATA_BITS-1] : shreg_n[0];
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = line_bit;
            ST_PARITY: tx_n = par_n;
            default:   tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four parameter variants, table-driven frames,
// a segment scoreboard for the serial line, plus reset-abort and back-to-back sequences.
module tb_uart_tx_param;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic [7:0] d_in;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] tx_v;
    logic [1:0] sel;
    logic       mon_tx;
    logic       mon_ready;
    logic       mon_busy;
    logic       mon_done;

    int tick_div = 1;
    int tick_cnt = 0;
    int applied = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int seg_idx = 0;

    typedef struct {
        logic tx;
        int   len;
        logic busy;
        logic done_first;
    } seg_t;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  word;
        int          div;
        int          nbits;
        logic [11:0] bits;
    } vec_t;

    seg_t seg_q[$];
    vec_t vecs[10];

    uart_tx_param u_def (
        .clk(clk), .reset(reset), .s_tick(s_tick), .d_in(d_in), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .busy(busy_v[0]), .tx_done_flag(done_v[0]), .tx(tx_v[0])
    );

    uart_tx_param #(.PARITY(2)) u_even (
        .clk(clk), .reset(reset), .s_tick(s_tick), .d_in(d_in), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .busy(busy_v[1]), .tx_done_flag(done_v[1]), .tx(tx_v[1])
    );

    uart_tx_param #(.PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .s_tick(s_tick), .d_in(d_in), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .busy(busy_v[2]), .tx_done_flag(done_v[2]), .tx(tx_v[2])
    );

    uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .STOP_BITS(2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .s_tick(s_tick), .d_in(d_in[6:0]), .tx_valid(valid_v[3]),
        .tx_ready(ready_v[3]), .busy(busy_v[3]), .tx_done_flag(done_v[3]), .tx(tx_v[3])
    );

    always_comb begin
        mon_tx    = tx_v[sel];
        mon_ready = ready_v[sel];
        mon_busy  = busy_v[sel];
        mon_done  = done_v[sel];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // s_tick changes shortly after the rising edge, one pulse every tick_div clocks
    initial begin
        s_tick = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (tick_cnt + 1 >= tick_div) tick_cnt = 0;
            else tick_cnt = tick_cnt + 1;
            s_tick = (tick_cnt == 0);
        end
    end

    function automatic int os_of(input logic [1:0] s);
        return (s == 2'd3) ? 4 : 16;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seg(input logic t, input int len, input logic b, input logic d);
        seg_t s;
        s.tx = t;
        s.len = len;
        s.busy = b;
        s.done_first = d;
        seg_q.push_back(s);
    endtask

    // Pops expected line segments and checks every cycle of each one; hooks drive inputs
    // after the check of cycle k (k counts from the first negedge after the accept edge).
    task automatic drain(input int din_at, input logic [7:0] din_val, input int drop_at,
                         input int rst_at);
        seg_t  s;
        logic  bad;
        logic  exp_done;
        string msg;
        int    k;
        k = 0;
        while (seg_q.size() > 0) begin
            s = seg_q.pop_front();
            bad = 1'b0;
            msg = "";
            for (int c = 0; c < s.len; c++) begin
                @(negedge clk);
                exp_done = s.done_first && (c == 0);
                if (!bad && (mon_tx !== s.tx || mon_busy !== s.busy ||
                             mon_ready !== !s.busy || mon_done !== exp_done)) begin
                    bad = 1'b1;
                    msg = $sformatf("FAIL seg%0d k=%0d tx/busy/ready/done: got %b%b%b%b expected %b%b%b%b",
                                    seg_idx, k, mon_tx, mon_busy, mon_ready, mon_done,
                                    s.tx, s.busy, !s.busy, exp_done);
                end
                if (mon_done === 1'b1) done_cnt++;
                if (k == din_at) d_in = din_val;
                if (k == drop_at) valid_v = '0;
                if (k == rst_at) reset = 1'b1;
                k++;
            end
            applied++;
            seg_idx++;
            if (bad) begin
                miscompares++;
                $display("%s", msg);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic aligned;
        tick_div = v.div;
        for (int i = v.nbits - 1; i >= 0; i--) push_seg(v.bits[i], os_of(v.sel) * v.div, 1'b1, 1'b0);
        push_seg(1'b1, 3, 1'b0, 1'b1);
        sel = v.sel;
        d_in = v.word;
        aligned = 1'b0;
        for (int n = 0; n < 8 && !aligned; n++) begin
            @(negedge clk);
            aligned = s_tick;
        end
        if (!aligned) begin
            miscompares++;
            $display("FAIL tick_align: got 0 expected 1");
        end
        chk($sformatf("ready_before_%0h", v.word), mon_ready, 1);
        valid_v[v.sel] = 1'b1;
        drain(0, ~v.word, 0, -1);
    endtask

    initial begin
        reset = 1'b1;
        valid_v = '0;
        d_in = '0;
        sel = 2'd0;

        vecs[0] = '{2'd0, 8'hA5, 1, 10, 12'b00_0_10100101_1};
        vecs[1] = '{2'd0, 8'h3C, 1, 10, 12'b00_0_00111100_1};
        vecs[2] = '{2'd0, 8'hA5, 3, 10, 12'b00_0_10100101_1};
        vecs[3] = '{2'd1, 8'hA5, 1, 11, 12'b0_0_10100101_0_1};
        vecs[4] = '{2'd2, 8'hA5, 1, 11, 12'b0_0_10100101_1_1};
        vecs[5] = '{2'd1, 8'h07, 1, 11, 12'b0_0_00000111_1_1};
        vecs[6] = '{2'd2, 8'h07, 2, 11, 12'b0_0_00000111_0_1};
        vecs[7] = '{2'd3, 8'h35, 1, 10, 12'b00_0_1010110_11};
        vecs[8] = '{2'd3, 8'h41, 2, 10, 12'b00_0_1000001_11};
        vecs[9] = '{2'd0, 8'h01, 2, 10, 12'b00_0_00000001_1};

        repeat (3) @(negedge clk);
        chk("reset_tx", tx_v, 4'hF);
        chk("reset_ready", ready_v, 4'hF);
        chk("reset_busy", busy_v, 4'h0);
        chk("reset_done", done_v, 4'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset in the middle of the second data bit of 0x96 aborts the frame.
        tick_div = 1;
        sel = 2'd0;
        d_in = 8'h96;
        push_seg(1'b0, 16, 1'b1, 1'b0);
        push_seg(1'b1, 16, 1'b1, 1'b0);
        push_seg(1'b0, 9, 1'b1, 1'b0);
        @(negedge clk);
        valid_v[0] = 1'b1;
        drain(0, 8'h00, 0, 40);
        @(negedge clk);
        chk("midrst_tx", mon_tx, 1);
        chk("midrst_ready", mon_ready, 1);
        chk("midrst_busy", mon_busy, 0);
        chk("midrst_done", mon_done, 0);
        reset = 1'b0;
        push_seg(1'b1, 40, 1'b0, 1'b0);
        drain(-1, 8'h00, -1, -1);
        run_vec(vecs[1]);

        // tx_valid held high across two frames: 0x01 then 0xFF, one idle clk between.
        done_cnt = 0;
        tick_div = 1;
        sel = 2'd0;
        d_in = 8'h01;
        push_seg(1'b0, 16, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) push_seg(1'b0, 16, 1'b1, 1'b0);
        push_seg(1'b1, 16, 1'b1, 1'b0);
        push_seg(1'b1, 16, 1'b1, 1'b0);
        push_seg(1'b1, 1, 1'b0, 1'b1);
        push_seg(1'b0, 16, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) push_seg(1'b1, 16, 1'b1, 1'b0);
        push_seg(1'b1, 40, 1'b0, 1'b1);
        @(negedge clk);
        valid_v[0] = 1'b1;
        drain(0, 8'hFF, 161, -1);
        chk("b2b_done_count", done_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one word per frame onto `tx`, with configurable data width, bit order, optional parity and 1 or 2 stop bits. Bit timing comes from an external `s_tick` enable pulse; one bit period is OVERSAMPLE ticks. The block sits between the host-side byte source (valid/ready handshake) and the serial line, and is paced by the shared baud/tick generator.

Parameters:
- DATA_BITS, 8, word width (5..9).
- OVERSAMPLE, 16, `s_tick` pulses per bit period (2..256).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bit count (1 or 2).
- MSB_FIRST, 1, bit order: 1 sends MSB first, 0 sends LSB first.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- s_tick, in, 1, bit-timing enable, one-clk pulse.
- d_in, in, DATA_BITS, word to transmit; sampled only on accept.
- tx_valid, in, 1, word on `d_in` is available.
- tx_ready, out, 1, block can accept a word (high only in IDLE).
- busy, out, 1, frame in progress (any state other than IDLE).
- tx_done_flag, out, 1, one-clk pulse at the end of the last stop bit.
- tx, out, 1, serial line; idle high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The port names are `clk` and `reset`.
- Reset state, effective at the next `clk` edge, regardless of current state:
  - state = IDLE; all counters cleared.
  - `tx` = 1, `tx_ready` = 1, `busy` = 0, `tx_done_flag` = 0.
  - A reset mid-frame aborts the frame immediately; no done pulse is produced.
- All outputs are registered.
- Accept: a word is accepted on an edge where `tx_valid` && `tx_ready`.
  - `d_in` is latched into a shift register.
  - Parity is computed from the latched word: odd means XOR of the data bits inverted; even means plain XOR.
  - The next state is START.
  - Changes to `d_in` after accept have no effect on the frame.
- States: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE.
- Line values per state:
  - START drives `tx` = 0.
  - DATA drives the current data bit, MSB or LSB per MSB_FIRST.
  - PARITY drives the parity bit.
  - STOP and IDLE drive 1.
  - `tx` reflects the new state on the cycle after the transition edge, so the first start-bit cycle is the cycle after accept.
- Tick counter `s_cnt` (width clog2(OVERSAMPLE)):
  - Cleared on every state or bit change.
  - Increments only on `s_tick`.
  - On `s_tick` with `s_cnt` == OVERSAMPLE-1, the current bit ends.
  - Cycles without `s_tick` hold all state; arbitrary tick spacing is legal.
- DATA: bit counter 0..DATA_BITS-1.
  - At each bit end, shift the register (left if MSB_FIRST, else right) and increment the bit counter.
  - After bit DATA_BITS-1, go to PARITY or STOP.
- STOP: lasts STOP_BITS x OVERSAMPLE ticks; the stop counter is reused from the bit counter.
- End of frame: at the final stop tick, go to IDLE and pulse `tx_done_flag` for exactly one clk.
  - `tx_ready` rises on that same edge.
- Back-to-back frames: if `tx_valid` is held high, the next word is accepted on the first IDLE cycle.
  - Minimum gap between frames is exactly 1 clk of IDLE (`tx` = 1) before the next start bit.
- Frame length in ticks: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) x OVERSAMPLE.
- Two related signals, never simultaneously asserted:
  - `tx_valid` while busy is ignored (`tx_ready` = 0).
  - `s_tick` during IDLE is ignored.

Test Plan:
- Defaults, `s_tick` every clk, send 0xA5:
  - `tx` sequence per 16-clk bit: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done_flag` pulses once, 160 clk after `tx` falls.
  - `tx_ready` is 0 throughout the frame.
- PARITY=2 (even) with 0xA5 -> parity bit 0. PARITY=1 (odd) with 0xA5 -> parity bit 1. Frame is 11 bit periods.
- MSB_FIRST=0, DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=4, send 0x35:
  - Data bits 1,0,1,0,1,1,0.
  - Stop high for 8 ticks.
  - Total 40 ticks.
- `s_tick` every 3rd clk: every bit lasts exactly 48 clk. Changing `d_in` mid-frame does not alter `tx`.
- Reset asserted mid-DATA:
  - Next cycle: `tx` = 1, `tx_ready` = 1, no `tx_done_flag`.
  - A new word (0x3C) afterwards transmits correctly.
- `tx_valid` held high with words 0x01 then 0xFF:
  - Second frame starts after exactly one idle clk.
  - Two `tx_done_flag` pulses.
  - Each word is accepted exactly once.
